// File: rtl/mem_responder_if.sv
// Bundles the CPU <-> memory responder handshake and bus signals.
// The shared data bus is split into its two directions: the CPU side
// drives wdata, the responder drives rdata and raises drive for exactly
// the cycles in which it owns the bus. Outside those cycles the
// responder's side is released (drive low, rdata zero).
interface mem_responder_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        drive;
  logic        valid;
  logic        error_not_present;
  logic        error_not_user;
  logic [31:0] page_table_base;
  logic        paging;
  logic        is_user;

  modport master (
    output address, read, write, wdata, page_table_base, paging, is_user,
    input  rdata, drive, valid, error_not_present, error_not_user
  );

  modport slave (
    input  address, read, write, wdata, page_table_base, paging, is_user,
    output rdata, drive, valid, error_not_present, error_not_user
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: services CPU read/write requests from an internal
// synchronous word RAM, optionally translating virtual addresses through a
// single-level page table held in the same RAM and enforcing present/user
// permission bits. Each request completes with a one-cycle valid pulse.
// Optional feature: define MEM_RESPONDER_TLB_EN to add a one-entry
// translation cache that lets repeated accesses to the same virtual page
// skip the page-table walk.
module mem_responder #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WALK, CHECK, ACCESS, RESPOND, TURN} state_t;

  state_t state;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       ram_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       phys_q;
  logic              read_q;
  logic              write_q;
  logic              valid_q;
  logic              np_q;
  logic              nu_q;
  logic              drive_q;
  logic              req;
  logic              ram_we;
  logic              pte_np;
  logic              pte_nu;
  logic [31:0]       pte_addr;
  logic [ADDR_W-1:0] pte_idx;
  logic [ADDR_W-1:0] ram_idx;

  assign req      = bus.read | bus.write;
  assign pte_addr = bus.page_table_base + {10'd0, addr_q[31:12], 2'b00};
  assign pte_idx  = pte_addr[ADDR_W+1:2];
  assign pte_np   = ~ram_q[0];
  assign pte_nu   = bus.is_user & ~ram_q[1];
  assign ram_we   = (state == ACCESS) & write_q;

`ifdef MEM_RESPONDER_TLB_EN
  logic              tlb_vld;
  logic [19:0]       tlb_vpn;
  logic [19:0]       tlb_frame;
  logic              tlb_u;
  logic [ADDR_W-1:0] tlb_pte_idx;
  logic [31:0]       base_q;
  logic              paging_q;
  logic              tlb_hit;
  logic              tlb_kill;

  // A hit is refused in the same cycle the table base moves, so a stale
  // entry is never used while the invalidation is still in flight.
  assign tlb_hit  = tlb_vld & bus.paging & (bus.address[31:12] == tlb_vpn) &
                    (bus.page_table_base == base_q);
  assign tlb_kill = (bus.page_table_base != base_q) | (paging_q & ~bus.paging) |
                    (ram_we & (ram_idx == tlb_pte_idx));
`endif

  // RAM word select: PTE during the walk, translated/physical word during access
  always_comb begin
    ram_idx = addr_q[ADDR_W+1:2];
    case (state)
      WALK:    ram_idx = pte_idx;
      ACCESS:  ram_idx = phys_q[ADDR_W+1:2];
      default: ram_idx = addr_q[ADDR_W+1:2];
    endcase
  end

  // Synchronous word RAM, read-before-write; contents survive reset
  always_ff @(posedge i_clk) begin
    if (ram_we) mem[ram_idx] <= wdata_q;
    ram_q <= mem[ram_idx];
  end

  // Request datapath: latched address, write data, translation and cache entry
  always_ff @(posedge i_clk) begin
    if (state == IDLE && req) begin
      addr_q  <= bus.address;
      wdata_q <= bus.wdata;
      phys_q  <= bus.address;
`ifdef MEM_RESPONDER_TLB_EN
      if (tlb_hit) phys_q <= {tlb_frame, bus.address[11:0]};
`endif
    end
    if (state == CHECK && !pte_np && !pte_nu) begin
      phys_q <= {ram_q[31:12], addr_q[11:0]};
`ifdef MEM_RESPONDER_TLB_EN
      tlb_vpn     <= addr_q[31:12];
      tlb_frame   <= ram_q[31:12];
      tlb_u       <= ram_q[1];
      tlb_pte_idx <= pte_idx;
`endif
    end
`ifdef MEM_RESPONDER_TLB_EN
    base_q <= bus.page_table_base;
`endif
  end

  // Transaction FSM with registered handshake and fault outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
      np_q    <= 1'b0;
      nu_q    <= 1'b0;
      drive_q <= 1'b0;
`ifdef MEM_RESPONDER_TLB_EN
      tlb_vld  <= 1'b0;
      paging_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // Simultaneous read and write resolves to a read.
            read_q  <= bus.read;
            write_q <= ~bus.read;
`ifdef MEM_RESPONDER_TLB_EN
            if (tlb_hit && bus.is_user && !tlb_u) begin
              nu_q    <= 1'b1;
              valid_q <= 1'b1;
              drive_q <= bus.read;
              state   <= RESPOND;
            end else if (tlb_hit) begin
              state <= ACCESS;
            end else begin
              state <= bus.paging ? WALK : ACCESS;
            end
`else
            state <= bus.paging ? WALK : ACCESS;
`endif
          end
        end
        WALK: state <= CHECK;
        CHECK: begin
          if (pte_np) begin
            np_q    <= 1'b1;
            valid_q <= 1'b1;
            drive_q <= read_q;
            state   <= RESPOND;
          end else if (pte_nu) begin
            nu_q    <= 1'b1;
            valid_q <= 1'b1;
            drive_q <= read_q;
            state   <= RESPOND;
          end else begin
            state <= ACCESS;
`ifdef MEM_RESPONDER_TLB_EN
            tlb_vld <= 1'b1;
`endif
          end
        end
        ACCESS: begin
          valid_q <= 1'b1;
          drive_q <= read_q;
          state   <= RESPOND;
        end
        RESPOND: begin
          valid_q <= 1'b0;
          np_q    <= 1'b0;
          nu_q    <= 1'b0;
          drive_q <= 1'b0;
          state   <= TURN;
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MEM_RESPONDER_TLB_EN
      paging_q <= bus.paging;
      if (tlb_kill) tlb_vld <= 1'b0;
`endif
    end
  end

  assign bus.valid             = valid_q;
  assign bus.error_not_present = np_q;
  assign bus.error_not_user    = nu_q;
  assign bus.drive             = drive_q;
  // Faulting reads return zero; otherwise the word registered during ACCESS.
  assign bus.rdata             = (drive_q & ~(np_q | nu_q)) ? ram_q : 32'd0;

  logic unused_bits;
  assign unused_bits = ^{addr_q[1:0], phys_q[31:ADDR_W+2], phys_q[1:0],
                         pte_addr[31:ADDR_W+2], pte_addr[1:0], ram_q[11:2]};

endmodule
